irq_source_ctrl: RTL and testbench

- Parametrised interrupt-source block that produces the CPU `irq_pins` vector.
- Channel 0 is a periodic timer. Channels 1..N_KEY are level sources, such as "keyboard ascii != 0", with typematic behaviour: a first event immediately, a second after an initial delay, then periodic repeat.
- Each channel has a pending latch that is cleared by per-channel ack or by global irq disable.
- Sits between the timer and keyboard driver and the pipeline's irq input. It replaces the ad-hoc timer/kb_state logic in the top level.

---
 rtl/irq_source_ctrl.sv | 90 +++++++++
 tb/tb_irq_source_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: periodic timer plus typematic level sources feeding a pending irq vector (IRQ_PRIO_ID_EN adds irq_any/irq_id)
module irq_source_ctrl #(
  parameter int N_KEY        = 1,
  parameter int CNT_W        = 32,
  parameter int TIMER_PERIOD = 50000000,
  parameter int REP_DELAY    = 25000000,
  parameter int REP_RATE     = 12500000,
  localparam int NCH         = N_KEY + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_en,
  input  logic [N_KEY-1:0] src_level,
  input  logic [NCH-1:0]   irq_ack,
  output logic [NCH-1:0]   irq_pins,
  output logic             timer_tick
`ifdef IRQ_PRIO_ID_EN
  ,
  output logic                                     irq_any,
  output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0]   irq_id
`endif
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMER_PERIOD - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REP_RATE - 1);
  logic [CNT_W-1:0] tcnt;
  logic             t_wrap;
  logic [NCH-1:0]   set_req;
  logic [NCH-1:0]   pend_nx;
  assign t_wrap     = tcnt == T_LAST;
  assign set_req[0] = t_wrap;
  // free-running timer; the tick follows the wrap by one cycle and ignores irq_en
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt       <= '0;
      timer_tick <= 1'b0;
    end else begin
      tcnt       <= t_wrap ? '0 : tcnt + CNT_W'(1);
      timer_tick <= t_wrap;
    end
  end
  for (genvar k = 0; k < N_KEY; k++) begin : g_src
    st_t              st, st_nx;
    logic [CNT_W-1:0] scnt, scnt_nx;
    logic             hit, ev;
    // typematic state and its period counter
    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        scnt <= '0;
      end else begin
        st   <= st_nx;
        scnt <= scnt_nx;
      end
    end
    // an event fires on the rise and at each expiry of the delay or repeat period
    always_comb begin
      hit     = scnt == (st == DELAY ? D_LAST : R_LAST) && st != IDLE;
      ev      = src_level[k] && (st == IDLE || hit);
      st_nx   = !src_level[k] ? IDLE : st == IDLE ? DELAY : (st == DELAY && hit) ? REPEAT : st;
      scnt_nx = (!src_level[k] || st == IDLE || hit) ? '0 : scnt + CNT_W'(1);
    end
    assign set_req[k+1] = ev;
  end
  assign pend_nx = irq_en ? (irq_pins & ~irq_ack) | set_req : '0;
  // pending latches: a new event beats a same-cycle ack, disable drops everything
  always_ff @(posedge clk) begin
    irq_pins <= rst ? '0 : pend_nx;
  end
`ifdef IRQ_PRIO_ID_EN
  localparam int IDW = NCH > 1 ? $clog2(NCH) : 1;
  logic [IDW-1:0] id_nx;
  // lowest pending index wins, so the timer has top priority
  always_comb begin
    id_nx = '0;
    for (int i = NCH - 1; i >= 0; i--) id_nx = pend_nx[i] ? IDW'(i) : id_nx;
  end
  // summary outputs registered alongside irq_pins
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_any <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_any <= |pend_nx;
      irq_id  <= id_nx;
    end
  end
`endif
endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed and random checks of irq_source_ctrl against an age-based reference model
module tb_irq_source_ctrl;
  localparam int NK = 2;
  localparam int TP = 10;
  localparam int RD = 8;
  localparam int RR = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          irq_en = 1'b1;
  logic [NK-1:0] src_level = '0;
  logic [NK:0]   irq_ack = '0;
  logic [NK:0]   irq_pins;
  logic          timer_tick;
`ifdef IRQ_PRIO_ID_EN
  logic          irq_any;
  logic [1:0]    irq_id;
`endif
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_t = 0;
  int age[NK];
  logic [NK:0] pend = '0;
  logic        tick_m = 1'b0;
  int rises[$];
  int ticks[$];

  irq_source_ctrl #(.N_KEY(NK), .CNT_W(32), .TIMER_PERIOD(TP), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clk(clk), .rst(rst), .irq_en(irq_en), .src_level(src_level), .irq_ack(irq_ack),
    .irq_pins(irq_pins), .timer_tick(timer_tick)
`ifdef IRQ_PRIO_ID_EN
    , .irq_any(irq_any), .irq_id(irq_id)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int q[$], input int e[$]);
    chk({tag, "_count"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++) chk(tag, (q.size() > i) ? q[i] : -1, e[i]);
  endtask

  // one clock: advance the model from the inputs seen at the edge, then compare
  task automatic step();
    logic [NK:0] ev;
    int id;
    @(posedge clk);
    if (rst) begin
      pend = '0; tick_m = 1'b0; n_t = 0; cyc = 0;
      for (int k = 0; k < NK; k++) age[k] = 0;
    end else begin
      ev = '0;
      ev[0] = (n_t % TP) == TP - 1;
      n_t++;
      for (int k = 0; k < NK; k++) begin
        if (src_level[k]) begin
          ev[k+1] = age[k] == 0 || age[k] == RD || (age[k] > RD && (age[k] - RD) % RR == 0);
          age[k]++;
        end else age[k] = 0;
      end
      tick_m = ev[0];
      pend = irq_en ? (pend & ~irq_ack) | ev : '0;
      cyc++;
    end
    #1;
    chk("pins", 32'(irq_pins), 32'(pend));
    chk("tick", 32'(timer_tick), 32'(tick_m));
`ifdef IRQ_PRIO_ID_EN
    id = 0;
    for (int i = NK; i >= 0; i--) if (pend[i]) id = i;
    chk("any", 32'(irq_any), 32'(pend != 0));
    chk("id", 32'(irq_id), id);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; irq_ack = '0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NK; k++) age[k] = 0;
    // timer wraps, stays pending, ack at 12
    do_reset();
    chk("reset_pins", 32'(irq_pins), 0);
    for (int i = 0; i < 31; i++) begin
      irq_ack = (cyc == 12) ? 3'b001 : 3'b000;
      step();
      if (timer_tick) ticks.push_back(cyc);
      if (cyc == 10 || cyc == 12 || cyc == 20) chk("timer_pend", 32'(irq_pins[0]), 1);
      if (cyc == 13 || cyc == 19) chk("timer_acked", 32'(irq_pins[0]), 0);
    end
    chk_q("timer_ticks", ticks, '{10, 20, 30});
    // typematic: held from 5 to 40, acked on each rise
    do_reset();
    rises.delete();
    for (int i = 0; i < 48; i++) begin
      src_level[0] = cyc >= 5 && cyc < 40;
      irq_ack = pend & 3'b010;
      step();
      if (irq_pins[1]) rises.push_back(cyc);
    end
    chk_q("typematic", rises, '{6, 14, 18, 22, 26, 30, 34, 38});
    // short press then quick re-press
    do_reset();
    rises.delete();
    for (int i = 0; i < 16; i++) begin
      src_level[0] = (cyc >= 2 && cyc < 5) || (cyc >= 7 && cyc < 10);
      irq_ack = pend & 3'b010;
      step();
      if (irq_pins[1]) rises.push_back(cyc);
    end
    chk_q("short_press", rises, '{3, 8});
    src_level = '0;
    // set wins over a same-cycle ack on channel 2
    do_reset();
    for (int i = 0; i < 12; i++) begin
      src_level[1] = 1'b1;
      irq_ack = (cyc == 8 || cyc == 10) ? 3'b100 : 3'b000;
      step();
      if (cyc == 9) chk("collision", 32'(irq_pins[2]), 1);
      if (cyc == 11) chk("ack_clear", 32'(irq_pins[2]), 0);
    end
    src_level = '0;
    // disable across a timer wrap
    do_reset();
    for (int i = 0; i < 21; i++) begin
      irq_ack = '0;
      irq_en = !(cyc >= 9 && cyc <= 11);
      step();
      if (cyc >= 10 && cyc < 20) chk("disabled_pins", 32'(irq_pins), 0);
      if (cyc == 10) chk("disabled_tick", 32'(timer_tick), 1);
    end
    irq_en = 1'b1;
    // reset while repeating, level held through it
    do_reset();
    src_level[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      irq_ack = pend & 3'b010;
      step();
    end
    rst = 1'b1; irq_ack = '0;
    step();
    chk("rst_mid_pins", 32'(irq_pins), 0);
    rst = 1'b0;
    rises.delete();
    for (int i = 0; i < 12; i++) begin
      irq_ack = pend & 3'b010;
      step();
      if (irq_pins[1]) rises.push_back(cyc);
    end
    chk_q("rst_restart", rises, '{1, 9});
    src_level = '0;
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 99) == 0;
      irq_en = $urandom_range(0, 19) != 0;
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 11) == 0) src_level[k] = ~src_level[k];
      irq_ack = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
